// File: rtl/norm_packer_pkg.sv
// Shared defaults and row type for the normalizer -> packer -> SRAM writer path.
package norm_packer_pkg;
  localparam int W_OUT_DEF  = 16;
  localparam int COL_DEF    = 8;
  localparam int N_ROWS_DEF = 8;

  typedef logic [COL_DEF-1:0][W_OUT_DEF-1:0] row_t;
endpackage

// File: rtl/norm_row_buf.sv
// One row register holding both streams, per-element write enable, plus a full flag.
module norm_row_buf #(
  parameter int W_OUT = 16,
  parameter int COL   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en_i,
  input  logic [$clog2(COL)-1:0]        wr_col_i,
  input  logic [W_OUT-1:0]              wr_dat1_i,
  input  logic [W_OUT-1:0]              wr_dat2_i,
  input  logic                          set_full_i,
  input  logic                          clr_full_i,
  output logic                          full_o,
  output logic [COL-1:0][W_OUT-1:0]     row1_o,
  output logic [COL-1:0][W_OUT-1:0]     row2_o
);
  logic                      full_q;
  logic [COL-1:0][W_OUT-1:0] row1_q, row2_q;

  always_ff @(posedge clk) begin
    if (reset)           full_q <= 1'b0;
    else if (set_full_i) full_q <= 1'b1;
    else if (clr_full_i) full_q <= 1'b0;
  end

  // Row contents carry no reset; validity is tracked solely by full_q.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      row1_q[wr_col_i] <= wr_dat1_i;
      row2_q[wr_col_i] <= wr_dat2_i;
    end
  end

  assign full_o = full_q;
  assign row1_o = row1_q;
  assign row2_o = row2_q;
endmodule

// File: rtl/norm_packer.sv
// Packs serial normalized elements into COL-wide rows via a two-entry ping-pong buffer.
// Row valid 1 cycle after its last beat; no upstream backpressure, rows dropped (sticky overflow) when full.
module norm_packer
  import norm_packer_pkg::*;
#(
  parameter int W_OUT  = W_OUT_DEF,
  parameter int COL    = COL_DEF,
  parameter int N_ROWS = N_ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        norm_valid,
  input  logic [W_OUT-1:0]            psum_norm_1,
  input  logic [W_OUT-1:0]            psum_norm_2,
  input  logic                        m_ready,
  output logic                        m_valid,
  output logic [COL*W_OUT-1:0]        m_data_1,
  output logic [COL*W_OUT-1:0]        m_data_2,
  output logic [$clog2(N_ROWS)-1:0]   m_addr,
  output logic                        m_last,
  output logic                        overflow
);
  localparam int CW = $clog2(COL);
  localparam int AW = $clog2(N_ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          keep_q, keep_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;

  logic [1:0]                      full;
  logic [1:0][COL-1:0][W_OUT-1:0]  row1_all, row2_all;
  logic                            row_start, keep_cur, wr_beat, row_fin, hs;

  // At column 0 the keep decision is taken live from the target buffer's full flag;
  // a buffer being drained this same cycle still reads as full, so that row is dropped.
  always_comb begin
    row_start  = norm_valid && (col_q == '0);
    keep_cur   = (col_q == '0) ? ~full[wr_ptr_q] : keep_q;
    wr_beat    = norm_valid && keep_cur;
    row_fin    = wr_beat && (col_q == CW'(COL-1));
    hs         = m_valid && m_ready;

    col_d      = norm_valid ? col_q + CW'(1) : col_q;
    keep_d     = row_start ? ~full[wr_ptr_q] : keep_q;
    overflow_d = overflow_q | (row_start && full[wr_ptr_q]);
    wr_ptr_d   = row_fin ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = hs ? ~rd_ptr_q : rd_ptr_q;
    addr_d     = hs ? addr_q + AW'(1) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      addr_q     <= '0;
      keep_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      addr_q     <= addr_d;
      keep_q     <= keep_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    norm_row_buf #(.W_OUT(W_OUT), .COL(COL)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_beat && (wr_ptr_q == 1'(b))),
      .wr_col_i   (col_q),
      .wr_dat1_i  (psum_norm_1),
      .wr_dat2_i  (psum_norm_2),
      .set_full_i (row_fin && (wr_ptr_q == 1'(b))),
      .clr_full_i (hs && (rd_ptr_q == 1'(b))),
      .full_o     (full[b]),
      .row1_o     (row1_all[b]),
      .row2_o     (row2_all[b])
    );
  end

  assign m_valid  = full[rd_ptr_q];
  assign m_data_1 = row1_all[rd_ptr_q];
  assign m_data_2 = row2_all[rd_ptr_q];
  assign m_addr   = addr_q;
  assign m_last   = m_valid && (addr_q == AW'(N_ROWS-1));
  assign overflow = overflow_q;
endmodule

// File: tb/tb_norm_packer.sv
// Directed bench for norm_packer: inputs driven and outputs sampled on the falling clock edge.
module tb_norm_packer;
  import norm_packer_pkg::*;

  logic         clk;
  logic         reset;
  logic         norm_valid;
  logic [15:0]  psum_norm_1, psum_norm_2;
  logic         m_ready;
  logic         m_valid;
  logic [127:0] m_data_1, m_data_2;
  logic [2:0]   m_addr;
  logic         m_last;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  norm_packer dut (
    .clk         (clk),
    .reset       (reset),
    .norm_valid  (norm_valid),
    .psum_norm_1 (psum_norm_1),
    .psum_norm_2 (psum_norm_2),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data_1    (m_data_1),
    .m_data_2    (m_data_2),
    .m_addr      (m_addr),
    .m_last      (m_last),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_row(input logic [15:0] base);
    row_t r;
    for (int k = 0; k < 8; k++) r[k] = base + 16'(k);
    return r;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] d1, input logic [15:0] d2);
    norm_valid  = 1'b1;
    psum_norm_1 = d1;
    psum_norm_2 = d2;
    @(negedge clk);
    norm_valid  = 1'b0;
  endtask

  task automatic send_row(input logic [15:0] b1, input logic [15:0] b2);
    for (int k = 0; k < 8; k++) beat(b1 + 16'(k), b2 + 16'(k));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    norm_valid = 1'b0;
    idle();
    idle();
    reset      = 1'b0;
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    do_reset();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
    total++; if (m_addr !== 3'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", m_addr); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", m_last); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow); end
    m_ready = 1'b1;
    idle(); idle();
    total++; if (m_addr !== 3'd0) begin bad++; $display("FAIL idle_ready_addr got=%0d want=0", m_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    m_ready = 1'b1;
    send_row(16'h0100, 16'h0200);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", m_valid); end
    total++; if (m_data_1 !== mk_row(16'h0100)) begin bad++; $display("FAIL basic_d1 got=%h want=%h", m_data_1, mk_row(16'h0100)); end
    total++; if (m_data_2 !== mk_row(16'h0200)) begin bad++; $display("FAIL basic_d2 got=%h want=%h", m_data_2, mk_row(16'h0200)); end
    total++; if (m_addr !== 3'd0) begin bad++; $display("FAIL basic_addr got=%0d want=0", m_addr); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL basic_last got=%b want=0", m_last); end
    idle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", m_valid); end
    total++; if (m_addr !== 3'd1) begin bad++; $display("FAIL basic_addr_inc got=%0d want=1", m_addr); end
  endtask

  task automatic test_gap();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) beat(16'h0100 + 16'(k), 16'h0200 + 16'(k));
    for (int g = 0; g < 5; g++) idle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL gap_early got=%b want=0", m_valid); end
    for (int k = 4; k < 8; k++) beat(16'h0100 + 16'(k), 16'h0200 + 16'(k));
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b want=1", m_valid); end
    total++; if (m_data_1 !== mk_row(16'h0100)) begin bad++; $display("FAIL gap_d1 got=%h want=%h", m_data_1, mk_row(16'h0100)); end
    total++; if (m_data_2 !== mk_row(16'h0200)) begin bad++; $display("FAIL gap_d2 got=%h want=%h", m_data_2, mk_row(16'h0200)); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL gap_ovf got=%b want=0", overflow); end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    send_row(16'h1000, 16'h2000);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid0 got=%b want=1", m_valid); end
    send_row(16'h1100, 16'h2100);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_held got=%b want=1", m_valid); end
    total++; if (m_data_1 !== mk_row(16'h1000)) begin bad++; $display("FAIL bp_stable got=%h want=%h", m_data_1, mk_row(16'h1000)); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", overflow); end
    send_row(16'h1200, 16'h2200);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", overflow); end
    total++; if (m_data_2 !== mk_row(16'h2000)) begin bad++; $display("FAIL bp_stable2 got=%h want=%h", m_data_2, mk_row(16'h2000)); end
    m_ready = 1'b1;
    total++; if (m_addr !== 3'd0) begin bad++; $display("FAIL bp_addr0 got=%0d want=0", m_addr); end
    idle();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid1 got=%b want=1", m_valid); end
    total++; if (m_addr !== 3'd1) begin bad++; $display("FAIL bp_addr1 got=%0d want=1", m_addr); end
    total++; if (m_data_1 !== mk_row(16'h1100)) begin bad++; $display("FAIL bp_row1 got=%h want=%h", m_data_1, mk_row(16'h1100)); end
    idle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", m_valid); end
    send_row(16'h1300, 16'h2300);
    total++; if (m_data_1 !== mk_row(16'h1300)) begin bad++; $display("FAIL bp_next_row got=%h want=%h", m_data_1, mk_row(16'h1300)); end
    total++; if (m_addr !== 3'd2) begin bad++; $display("FAIL bp_next_addr got=%0d want=2", m_addr); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b want=1", overflow); end
    idle();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_addr;
    logic       exp_last;
    do_reset();
    m_ready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      send_row(16'h3000 + 16'(r << 8), 16'h4000 + 16'(r << 8));
      exp_addr = 3'(r % 8);
      exp_last = (r == 7);
      total++; if (m_addr !== exp_addr) begin bad++; $display("FAIL wrap_addr r=%0d got=%0d want=%0d", r, m_addr, exp_addr); end
      total++; if (m_last !== exp_last) begin bad++; $display("FAIL wrap_last r=%0d got=%b want=%b", r, m_last, exp_last); end
    end
    idle();
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL wrap_last_idle got=%b want=0", m_last); end
  endtask

  task automatic test_simul();
    do_reset();
    m_ready = 1'b0;
    send_row(16'h5000, 16'h6000);
    for (int k = 0; k < 7; k++) beat(16'h5100 + 16'(k), 16'h6100 + 16'(k));
    total++; if (m_data_1 !== mk_row(16'h5000)) begin bad++; $display("FAIL sim_pending got=%h want=%h", m_data_1, mk_row(16'h5000)); end
    m_ready = 1'b1;
    beat(16'h5107, 16'h6107);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL sim_valid got=%b want=1", m_valid); end
    total++; if (m_addr !== 3'd1) begin bad++; $display("FAIL sim_addr got=%0d want=1", m_addr); end
    total++; if (m_data_1 !== mk_row(16'h5100)) begin bad++; $display("FAIL sim_row2 got=%h want=%h", m_data_1, mk_row(16'h5100)); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_ovf got=%b want=0", overflow); end
    idle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sim_drained got=%b want=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) beat(16'h7000 + 16'(k), 16'h7100 + 16'(k));
    do_reset();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", m_valid); end
    send_row(16'h8000, 16'h8100);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_row_valid got=%b want=1", m_valid); end
    total++; if (m_addr !== 3'd0) begin bad++; $display("FAIL mid_addr got=%0d want=0", m_addr); end
    total++; if (m_data_1 !== mk_row(16'h8000)) begin bad++; $display("FAIL mid_d1 got=%h want=%h", m_data_1, mk_row(16'h8000)); end
    total++; if (m_data_2 !== mk_row(16'h8100)) begin bad++; $display("FAIL mid_d2 got=%h want=%h", m_data_2, mk_row(16'h8100)); end
    idle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_extra got=%b want=0", m_valid); end
  endtask

  initial begin
    reset       = 1'b1;
    norm_valid  = 1'b0;
    psum_norm_1 = '0;
    psum_norm_2 = '0;
    m_ready     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_wrap();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
